// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ICACHE_INDEX_BITS = 6;
  localparam int ICACHE_WORD_BITS  = 2;
  localparam logic [31:0] NULL32   = 32'h0000_0000;

  typedef enum logic {
    ICACHE_IDLE   = 1'b0,
    ICACHE_REFILL = 1'b1
  } icacheState_e;

  // Clears the byte and word offset so the result points at the first word of the line.
  function automatic logic [31:0] lineBase(input logic [31:0] addr, input int wordBits);
    logic [31:0] mask;
    mask = (32'd1 << (wordBits + 2)) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache; slave is the cache, master drives it.
interface icache_if;
  logic [31:0] pc_in;
  logic        is_stall_IC;
  logic        stall_ID;
  logic        jp_wrong;
  logic        ins_flag;
  logic [31:0] ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport slave (
    input  pc_in, is_stall_IC, stall_ID, jp_wrong, mem_ready, mem_data,
    output ins_flag, ins, mem_req, mem_addr
  );

  modport master (
    output pc_in, is_stall_IC, stall_ID, jp_wrong, mem_ready, mem_data,
    input  ins_flag, ins, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_refill.sv
// Line refill sequencer: walks the words of one line, issuing one memory request per word.
module icache_refill
  import icache_pkg::*;
#(
  parameter int WORD_BITS = ICACHE_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 start_i,
  input  logic [31:0]          base_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic [31:0]          mem_addr_o,
  output logic [WORD_BITS-1:0] wordCnt_o,
  output logic                 fillWe_o,
  output logic                 done_o
);

  logic                 active_q, active_d;
  logic [31:0]          base_q, base_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;

  assign fillWe_o   = active_q & mem_ready_i & rdy;
  assign done_o     = fillWe_o & (cnt_q == '1);
  assign mem_req_o  = active_q;
  assign mem_addr_o = base_q + {{(30 - WORD_BITS){1'b0}}, cnt_q, 2'b00};
  assign wordCnt_o  = cnt_q;

  always_comb begin
    active_d = active_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      base_d   = base_i;
      cnt_d    = '0;
    end else if (fillWe_o) begin
      cnt_d = cnt_q + WORD_BITS'(1);
      if (cnt_q == '1) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      base_q   <= NULL32;
      cnt_q    <= '0;
    end else if (rdy) begin
      active_q <= active_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one lookup per cycle, whole-line refill on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int WORD_BITS  = ICACHE_WORD_BITS
) (
  input logic     clk,
  input logic     rst,
  input logic     rdy,
  icache_if.slave bus
);

  localparam int TAG_BITS = 32 - 2 - WORD_BITS - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << (INDEX_BITS + WORD_BITS);

  logic [31:0]          dataArr_q [WORDS];
  logic [TAG_BITS-1:0]  tagArr_q  [LINES];
  logic [LINES-1:0]     valid_q;

  icacheState_e state_q, state_d;
  logic [31:0]  reqPc_q, reqPc_d;
  logic         insFlag_q, insFlag_d;
  logic [31:0]  ins_q, ins_d;
  logic         flushPending_q, flushPending_d;

  logic [INDEX_BITS-1:0] pcIdx, reqIdx;
  logic [WORD_BITS-1:0]  pcWord, reqWord, wordCnt;
  logic [TAG_BITS-1:0]   pcTag, reqTag;
  logic                  hit, refillStart, fillWe, refillDone;
  logic [31:0]           lookupData, deliverData;
  logic                  unusedOffsetBits;

  assign pcWord  = bus.pc_in[WORD_BITS+1:2];
  assign pcIdx   = bus.pc_in[WORD_BITS+2 +: INDEX_BITS];
  assign pcTag   = bus.pc_in[31 -: TAG_BITS];
  assign reqWord = reqPc_q[WORD_BITS+1:2];
  assign reqIdx  = reqPc_q[WORD_BITS+2 +: INDEX_BITS];
  assign reqTag  = reqPc_q[31 -: TAG_BITS];
  assign unusedOffsetBits = ^{bus.pc_in[1:0], reqPc_q[1:0]};

  assign hit        = valid_q[pcIdx] && (tagArr_q[pcIdx] == pcTag);
  assign lookupData = dataArr_q[{pcIdx, pcWord}];
  // The last refill word is still on mem_data when done fires, so it has to be forwarded.
  assign deliverData = (reqWord == wordCnt) ? bus.mem_data : dataArr_q[{reqIdx, reqWord}];

  icache_refill #(.WORD_BITS(WORD_BITS)) u_refill (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .start_i     (refillStart),
    .base_i      (lineBase(bus.pc_in, WORD_BITS)),
    .mem_ready_i (bus.mem_ready),
    .mem_req_o   (bus.mem_req),
    .mem_addr_o  (bus.mem_addr),
    .wordCnt_o   (wordCnt),
    .fillWe_o    (fillWe),
    .done_o      (refillDone)
  );

  always_comb begin
    state_d        = state_q;
    reqPc_d        = reqPc_q;
    insFlag_d      = insFlag_q;
    ins_d          = ins_q;
    flushPending_d = flushPending_q;
    refillStart    = 1'b0;
    case (state_q)
      ICACHE_IDLE: begin
        if (bus.jp_wrong) begin
          insFlag_d = 1'b0;
        end else if (bus.stall_ID) begin
          insFlag_d = insFlag_q;
        end else if (bus.is_stall_IC) begin
          insFlag_d = 1'b0;
        end else begin
          reqPc_d = bus.pc_in;
          if (hit) begin
            insFlag_d = 1'b1;
            ins_d     = lookupData;
          end else begin
            insFlag_d      = 1'b0;
            refillStart    = rdy;
            flushPending_d = 1'b0;
            state_d        = ICACHE_REFILL;
          end
        end
      end
      ICACHE_REFILL: begin
        insFlag_d = 1'b0;
        if (bus.jp_wrong) begin
          flushPending_d = 1'b1;
        end
        // A flush arriving on the final word cycle also suppresses delivery.
        if (refillDone) begin
          state_d        = ICACHE_IDLE;
          flushPending_d = 1'b0;
          if (!(flushPending_q || bus.jp_wrong)) begin
            insFlag_d = 1'b1;
            ins_d     = deliverData;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ICACHE_IDLE;
      reqPc_q        <= NULL32;
      insFlag_q      <= 1'b0;
      ins_q          <= NULL32;
      flushPending_q <= 1'b0;
      valid_q        <= '0;
    end else if (rdy) begin
      state_q        <= state_d;
      reqPc_q        <= reqPc_d;
      insFlag_q      <= insFlag_d;
      ins_q          <= ins_d;
      flushPending_q <= flushPending_d;
      if (refillDone) begin
        valid_q[reqIdx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fillWe) begin
      dataArr_q[{reqIdx, wordCnt}] <= bus.mem_data;
    end
    if (refillDone) begin
      tagArr_q[reqIdx] <= reqTag;
    end
  end

  assign bus.ins_flag = insFlag_q;
  assign bus.ins      = ins_q;

endmodule
